// File: rtl/adc_pkt_serializer.sv
// Framed serializer: snapshots NCH ADC samples and streams header + enabled channel words.
// Optional ADC_PKT_SERIALIZER_SELF_TEST_EN adds a self_test input that substitutes a word counter for sample data.
module adc_pkt_serializer #(
    parameter int unsigned NCH      = 24,
    parameter int unsigned SAMPLE_W = 36,
    parameter int unsigned OUT_W    = 18,
    parameter int unsigned IDLE_W   = 16
) (
    input  logic                    pktctrl_clk,
    input  logic                    pktctrl_rstn,
    input  logic [NCH*SAMPLE_W-1:0] adc_data,
    input  logic                    capture_start,
    input  logic                    capture_stop,
    input  logic                    capture_mode,
    input  logic [7:0]              pkt_num,
    input  logic [NCH-1:0]          ch_en,
    input  logic [IDLE_W-1:0]       idle_len,
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
    input  logic                    self_test,
`endif
    output logic [OUT_W-1:0]        dout,
    output logic                    dout_valid,
    output logic                    busy,
    output logic                    done
);
    localparam int unsigned WPS  = SAMPLE_W / OUT_W;
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned WD_W = (WPS > 1) ? $clog2(WPS) : 1;
    localparam int unsigned FC_W = OUT_W - 4;

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_GAP, ST_DONE} state_t;

    state_t                  state_q;
    logic [NCH*SAMPLE_W-1:0] snap_q;
    logic                    mode_q;
    logic [7:0]              pnum_q;
    logic [NCH-1:0]          en_q;
    logic [IDLE_W-1:0]       idle_q;
    logic [NCH-1:0]          rem_q;
    logic [WD_W-1:0]         wd_q;
    logic [FC_W-1:0]         frame_q;
    logic [7:0]              pkt_q;
    logic [IDLE_W-1:0]       gap_q;
    logic                    stop_q;
    logic [OUT_W-1:0]        dout_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
    logic                    st_q;
    logic [SAMPLE_W-1:0]     stcnt_q;
`endif

    logic [CH_W-1:0]  nxt_ch_d;
    logic [OUT_W-1:0] word_d;
    logic [7:0]       pkt_inc_d;
    logic [7:0]       pnum_eff_d;
    logic             stop_now_d;
    logic             eop_d;
    logic             gap_end_d;
    logic             launch_d;
    logic             finish_d;
    logic [FC_W-1:0]  hdr_frame_d;
    int unsigned      base_d;
    int unsigned      off_d;

    always_comb begin
        nxt_ch_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rem_q[NCH-1-i]) nxt_ch_d = CH_W'(NCH-1-i);
        end
        off_d  = (WPS - 1 - 32'(wd_q)) * OUT_W;
        base_d = 32'(nxt_ch_d) * SAMPLE_W + off_d;
        word_d = snap_q[base_d +: OUT_W];
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
        if (st_q) word_d = stcnt_q[off_d +: OUT_W];
`endif
        pkt_inc_d   = pkt_q + 8'd1;
        pnum_eff_d  = (pnum_q == 8'd0) ? 8'd1 : pnum_q;
        stop_now_d  = stop_q | capture_stop;
        eop_d       = (state_q == ST_HDR || state_q == ST_DATA) && (rem_q == '0);
        gap_end_d   = (state_q == ST_GAP) && (gap_q == '0);
        // End of packet without a gap decides using the counter value being written this edge.
        finish_d    = (eop_d && idle_q == '0 && (stop_now_d || (!mode_q && pkt_inc_d == pnum_eff_d)))
                   || (gap_end_d && (stop_now_d || (!mode_q && pkt_q == pnum_eff_d)));
        launch_d    = ((eop_d && idle_q == '0) || gap_end_d) && !finish_d;
        hdr_frame_d = eop_d ? frame_q + FC_W'(1) : frame_q;
    end

    always_ff @(posedge pktctrl_clk or negedge pktctrl_rstn) begin
        if (!pktctrl_rstn) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            mode_q  <= 1'b0;
            pnum_q  <= '0;
            en_q    <= '0;
            idle_q  <= '0;
            rem_q   <= '0;
            wd_q    <= '0;
            frame_q <= '0;
            pkt_q   <= '0;
            gap_q   <= '0;
            stop_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
            st_q    <= 1'b0;
            stcnt_q <= '0;
`endif
        end else begin
            if (busy_q && capture_stop) stop_q <= 1'b1;
            if (eop_d) begin
                frame_q <= frame_q + FC_W'(1);
                pkt_q   <= pkt_inc_d;
            end
            if (launch_d) begin
                snap_q  <= adc_data;
                rem_q   <= en_q;
                wd_q    <= '0;
                dout_q  <= {4'hA, hdr_frame_d};
                valid_q <= 1'b1;
                state_q <= ST_HDR;
            end else if (finish_d) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (capture_start) begin
                            mode_q  <= capture_mode;
                            pnum_q  <= pkt_num;
                            en_q    <= ch_en;
                            idle_q  <= idle_len;
                            snap_q  <= adc_data;
                            rem_q   <= ch_en;
                            wd_q    <= '0;
                            frame_q <= '0;
                            pkt_q   <= '0;
                            stop_q  <= 1'b0;
                            dout_q  <= {4'hA, FC_W'(0)};
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= ST_HDR;
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
                            st_q    <= self_test;
                            stcnt_q <= '0;
`endif
                        end
                    end
                    ST_HDR, ST_DATA: begin
                        if (rem_q != '0) begin
                            dout_q  <= word_d;
                            valid_q <= 1'b1;
                            state_q <= ST_DATA;
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
                            stcnt_q <= stcnt_q + SAMPLE_W'(1);
`endif
                            if (wd_q == WD_W'(WPS - 1)) begin
                                wd_q  <= '0;
                                rem_q <= rem_q & ~(NCH'(1) << nxt_ch_d);
                            end else begin
                                wd_q <= wd_q + WD_W'(1);
                            end
                        end else begin
                            gap_q   <= idle_q - IDLE_W'(1);
                            dout_q  <= '0;
                            valid_q <= 1'b0;
                            state_q <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        gap_q   <= gap_q - IDLE_W'(1);
                        dout_q  <= '0;
                        valid_q <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_adc_pkt_serializer.sv
// Randomized/directed bench for adc_pkt_serializer with a packet-list reference model (NCH=4, SAMPLE_W=36, OUT_W=18).
module tb_adc_pkt_serializer;
    logic         clk = 1'b0;
    logic         rstn;
    logic [143:0] adc_data;
    logic         capture_start, capture_stop, capture_mode;
    logic [7:0]   pkt_num;
    logic [3:0]   ch_en;
    logic [15:0]  idle_len;
    logic [17:0]  dout;
    logic         dout_valid, busy, done;
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
    logic         self_test;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [35:0] samp [8][4];

    adc_pkt_serializer #(.NCH(4), .SAMPLE_W(36), .OUT_W(18), .IDLE_W(16)) dut (
        .pktctrl_clk  (clk),
        .pktctrl_rstn (rstn),
        .adc_data     (adc_data),
        .capture_start(capture_start),
        .capture_stop (capture_stop),
        .capture_mode (capture_mode),
        .pkt_num      (pkt_num),
        .ch_en        (ch_en),
        .idle_len     (idle_len),
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
        .self_test    (self_test),
`endif
        .dout         (dout),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] pack(input int p);
        logic [143:0] r;
        for (int k = 0; k < 4; k++) r[k*36 +: 36] = samp[p][k];
        return r;
    endfunction

    task automatic rand_samps();
        for (int p = 0; p < 8; p++)
            for (int k = 0; k < 4; k++) samp[p][k] = 36'({$urandom, $urandom});
    endtask

    task automatic scramble_cfg();
        capture_mode = 1'($urandom);
        pkt_num      = 8'($urandom);
        ch_en        = 4'($urandom);
        idle_len     = 16'($urandom);
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
        self_test    = 1'($urandom);
`endif
    endtask

    // Model: a capture is a list of packets; each is header, enabled channel words MS first, then idle_len blanks.
    task automatic run_capture(input string name, input bit mode, input logic [7:0] pn, input logic [3:0] en,
                               input logic [15:0] il, input int stop_pkt, input bit stop_at_start, input bit st);
        bit          ev[$];
        logic [17:0] ed[$];
        int          hdr_idx[$];
        int          npk;
        logic [35:0] v;
        logic [35:0] stc;
        npk = mode ? stop_pkt + 1 : ((pn == 0) ? 1 : int'(pn));
        stc = '0;
        for (int p = 0; p < npk; p++) begin
            hdr_idx.push_back(ev.size());
            ev.push_back(1'b1); ed.push_back({4'hA, 14'(p)});
            for (int k = 0; k < 4; k++) begin
                if (en[k]) begin
                    for (int w = 0; w < 2; w++) begin
                        v = st ? stc : samp[p][k];
                        stc++;
                        ev.push_back(1'b1); ed.push_back(v[(1-w)*18 +: 18]);
                    end
                end
            end
            for (int g = 0; g < int'(il); g++) begin
                ev.push_back(1'b0); ed.push_back('0);
            end
        end

        adc_data = pack(0);
        capture_mode = mode; pkt_num = pn; ch_en = en; idle_len = il;
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
        self_test = st;
`endif
        capture_start = 1'b1; capture_stop = stop_at_start;
        @(posedge clk); #1;
        capture_start = 1'b0; capture_stop = 1'b0;
        scramble_cfg();
        for (int c = 0; c < ev.size(); c++) begin
            chk({name, ".valid"}, 36'(dout_valid), 36'(ev[c]));
            chk({name, ".dout"}, 36'(dout), 36'(ed[c]));
            chk({name, ".busy"}, 36'(busy), 36'd1);
            chk({name, ".done"}, 36'(done), 36'd0);
            capture_start = (c == 1);
            capture_stop  = 1'b0;
            for (int p = 0; p < npk; p++) begin
                if (c == hdr_idx[p]) adc_data = pack(p + 1);
                if (mode && p == stop_pkt && c == hdr_idx[p] + 1) capture_stop = 1'b1;
            end
            @(posedge clk); #1;
        end
        capture_start = 1'b0; capture_stop = 1'b0;
        for (int h = 0; h < 2; h++) begin
            chk({name, ".end_done"}, 36'(done), 36'd1);
            chk({name, ".end_busy"}, 36'(busy), 36'd0);
            chk({name, ".end_valid"}, 36'(dout_valid), 36'd0);
            chk({name, ".end_dout"}, 36'(dout), 36'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rstn = 1'b0;
        adc_data = '0; capture_start = 1'b0; capture_stop = 1'b0; capture_mode = 1'b0;
        pkt_num = '0; ch_en = '0; idle_len = '0;
`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
        self_test = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst.dout", 36'(dout), 36'd0);
        chk("rst.valid", 36'(dout_valid), 36'd0);
        chk("rst.busy", 36'(busy), 36'd0);
        chk("rst.done", 36'(done), 36'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int p = 0; p < 8; p++)
            for (int k = 0; k < 4; k++) samp[p][k] = {4'(k), 28'h0, 4'(k)};
        run_capture("single", 1'b0, 8'd1, 4'hF, 16'd0, 0, 1'b0, 1'b0);

        rand_samps();
        run_capture("mask", 1'b0, 8'd1, 4'b0101, 16'd0, 0, 1'b0, 1'b0);
        rand_samps();
        run_capture("multi_gap", 1'b0, 8'd3, 4'hF, 16'd5, 0, 1'b0, 1'b0);
        rand_samps();
        run_capture("cont_stop", 1'b1, 8'd0, 4'b1010, 16'd3, 1, 1'b0, 1'b0);
        rand_samps();
        run_capture("cont_stop_nogap", 1'b1, 8'd1, 4'b0110, 16'd0, 1, 1'b0, 1'b0);
        rand_samps();
        run_capture("pkt0", 1'b0, 8'd0, 4'b1000, 16'd1, 0, 1'b0, 1'b0);
        rand_samps();
        run_capture("hdr_only", 1'b0, 8'd2, 4'h0, 16'd2, 0, 1'b0, 1'b0);
        rand_samps();
        run_capture("start_stop", 1'b0, 8'd2, 4'b0011, 16'd1, 0, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rand_samps();
            run_capture("rand", 1'b0, 8'($urandom_range(1, 3)), 4'($urandom),
                        16'($urandom_range(0, 4)), 0, 1'b0, 1'b0);
        end

        rand_samps();
        adc_data = pack(0);
        capture_mode = 1'b1; pkt_num = 8'd1; ch_en = 4'hF; idle_len = 16'd0;
        capture_start = 1'b1;
        @(posedge clk); #1;
        capture_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst.valid", 36'(dout_valid), 36'd0);
        chk("async_rst.busy", 36'(busy), 36'd0);
        chk("async_rst.done", 36'(done), 36'd0);
        chk("async_rst.dout", 36'(dout), 36'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        rand_samps();
        run_capture("after_rst", 1'b0, 8'd2, 4'b1001, 16'd1, 0, 1'b0, 1'b0);

`ifdef ADC_PKT_SERIALIZER_SELF_TEST_EN
        rand_samps();
        run_capture("self_test", 1'b0, 8'd1, 4'hF, 16'd0, 0, 1'b0, 1'b1);
        rand_samps();
        run_capture("self_test_multi", 1'b0, 8'd2, 4'b0110, 16'd2, 0, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
